minisys_mdu: RTL and testbench

Multiply/divide unit in the EXE stage. It performs MULT/MULTU/DIV/DIVU over multiple cycles. It drives the busy/over/keep handshake that the decode stage uses to stall mfhi/mflo/md instructions, and it drives the HI/LO write-back strobe and data. It is the producer end of the md interface that the decode stage consumes: mdcs, keepmd, mdhidata/mdlodata, multbusy/multover and divbusy/divover.

---
 rtl/minisys_md_pkg.sv | 28 ++
 rtl/minisys_mdu_if.sv | 39 +++
 rtl/minisys_div_core.sv | 58 +++++
 rtl/minisys_mdu.sv | 146 ++++++++++++++
 tb/tb_minisys_mdu.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/minisys_md_pkg.sv
// rtl/minisys_md_pkg.sv - shared op codes, FSM encoding and constants for the multiply/divide unit
//
// Purpose : common definitions imported by the md interface, the divide core and the MDU top.
// Ports   : none (package).

package minisys_md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    // op[1] selects the divide family
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/minisys_mdu_if.sv
// rtl/minisys_mdu_if.sv - md handshake/result bundle between EXE-stage MDU and decode
//
// Purpose : groups the start request, operands and the busy/over/keep/HI-LO result signals.
// Signals : mdE, alu_mdE, srca, srcb          (decode/EXE -> MDU)
//           keepmdE, multbusyE, multoverE,
//           divbusyE, divoverE, mdcsE2D,
//           mdhidataE2D, mdlodataE2D         (MDU -> decode)
// Modports: slave  - the MDU (producer of results)
//           master - the pipeline side driving requests and consuming results

interface minisys_mdu_if;

    logic        mdE;
    logic [1:0]  alu_mdE;
    logic [31:0] srca;
    logic [31:0] srcb;

    logic        keepmdE;
    logic        multbusyE;
    logic        multoverE;
    logic        divbusyE;
    logic        divoverE;
    logic        mdcsE2D;
    logic [31:0] mdhidataE2D;
    logic [31:0] mdlodataE2D;

    modport slave (
        input  mdE, alu_mdE, srca, srcb,
        output keepmdE, multbusyE, multoverE, divbusyE, divoverE,
               mdcsE2D, mdhidataE2D, mdlodataE2D
    );

    modport master (
        output mdE, alu_mdE, srca, srcb,
        input  keepmdE, multbusyE, multoverE, divbusyE, divoverE,
               mdcsE2D, mdhidataE2D, mdlodataE2D
    );

endinterface

// File: rtl/minisys_div_core.sv
// rtl/minisys_div_core.sv - radix-2 restoring divide datapath on unsigned magnitudes
//
// Purpose : one quotient bit per enabled cycle; 32 enabled cycles after a load give the result.
// Ports   : clk, rst            clock, synchronous active-high reset
//           i_load             load dividend/divisor, clear the partial remainder
//           i_en               perform one shift/subtract/compare step
//           i_dividend[31:0]   unsigned dividend magnitude
//           i_divisor[31:0]    unsigned divisor magnitude
//           o_quotient[31:0]   quotient (valid after 32 steps)
//           o_remainder[31:0]  remainder (valid after 32 steps)

module minisys_div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while new quotient bits enter at the LSB.
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_en) begin
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/minisys_mdu.sv
// rtl/minisys_mdu.sv - EXE-stage multiply/divide unit with decode-stall handshake
//
// Purpose : MULT/MULTU (MULT_LAT cycles) and DIV/DIVU (34 cycles) with HI/LO write strobe.
// Ports   : clk  clock
//           rst  synchronous active-high reset
//           md   minisys_mdu_if.slave: mdE/alu_mdE/srca/srcb in;
//                keepmdE, multbusyE, multoverE, divbusyE, divoverE, mdcsE2D,
//                mdhidataE2D, mdlodataE2D out (all registered / state-decoded)

module minisys_mdu
    import minisys_md_pkg::*;
#(
    parameter int MULT_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    minisys_mdu_if.slave   md
);

    md_state_t   r_state;
    md_state_t   w_next;
    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_srca;
    logic [31:0] r_srcb;
    logic [63:0] r_prod;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_mul_sig;
    logic        w_div_sig;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_q_neg;
    logic        w_r_neg;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    localparam logic [5:0] MUL_LAST = 6'(MULT_LAT - 2);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    // DONE accepts a new start so back-to-back ops have no bubble
    assign w_accept = md.mdE && (r_state == ST_IDLE || r_state == ST_DONE);

    // Single 64x64 multiplier; signedness is just the extension bit
    assign w_mul_sig = (md.alu_mdE == MD_MULT);
    assign w_ext_a   = {{32{w_mul_sig & md.srca[31]}}, md.srca};
    assign w_ext_b   = {{32{w_mul_sig & md.srcb[31]}}, md.srcb};
    assign w_prod    = w_ext_a * w_ext_b;

    assign w_div_sig = (md.alu_mdE == MD_DIV);
    assign w_abs_a   = (w_div_sig && md.srca[31]) ? (~md.srca + 32'd1) : md.srca;
    assign w_abs_b   = (w_div_sig && md.srcb[31]) ? (~md.srcb + 32'd1) : md.srcb;

    minisys_div_core u_div (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_en        (r_state == ST_DIV),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // 0x80000000 / -1 needs no special case: magnitude quotient 0x80000000
    // negates back to itself with a zero remainder.
    assign w_q_neg = (r_op == MD_DIV) && (r_srca[31] ^ r_srcb[31]);
    assign w_r_neg = (r_op == MD_DIV) && r_srca[31];
    assign w_q_fix = w_q_neg ? (~w_quo + 32'd1) : w_quo;
    assign w_r_fix = w_r_neg ? (~w_rem + 32'd1) : w_rem;

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = md_is_div(md.alu_mdE) ? ST_DIV : ST_MUL;
                else          w_next = ST_IDLE;
            end
            ST_MUL:  w_next = (r_cnt == MUL_LAST) ? ST_DONE : ST_MUL;
            ST_DIV:  w_next = (r_cnt == DIV_LAST) ? ST_FIX  : ST_DIV;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: begin
                if (w_accept) w_next = md_is_div(md.alu_mdE) ? ST_DIV : ST_MUL;
                else          w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_MULT;
            r_srca  <= '0;
            r_srcb  <= '0;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_cnt  <= '0;
                r_op   <= md.alu_mdE;
                r_srca <= md.srca;
                r_srcb <= md.srcb;
                r_prod <= w_prod;
            end else if (r_state == ST_MUL || r_state == ST_DIV) begin
                r_cnt  <= r_cnt + 6'd1;
            end

            if (r_state == ST_MUL && w_next == ST_DONE) begin
                r_hi <= r_prod[63:32];
                r_lo <= r_prod[31:0];
            end else if (r_state == ST_FIX) begin
                // Divide by zero reports all-ones quotient and the raw dividend
                if (r_srcb == 32'd0) begin
                    r_hi <= r_srca;
                    r_lo <= 32'hFFFF_FFFF;
                end else begin
                    r_hi <= w_r_fix;
                    r_lo <= w_q_fix;
                end
            end
        end
    end

    assign md.keepmdE     = (r_state == ST_MUL) || (r_state == ST_DIV) ||
                            (r_state == ST_FIX) || (r_state == ST_DONE);
    assign md.multbusyE   = (r_state == ST_MUL);
    assign md.divbusyE    = (r_state == ST_DIV) || (r_state == ST_FIX);
    assign md.multoverE   = (r_state == ST_DONE) && !md_is_div(r_op);
    assign md.divoverE    = (r_state == ST_DONE) &&  md_is_div(r_op);
    assign md.mdcsE2D     = (r_state == ST_DONE);
    assign md.mdhidataE2D = r_hi;
    assign md.mdlodataE2D = r_lo;

endmodule

// File: tb/tb_minisys_mdu.sv
// tb/tb_minisys_mdu.sv - directed self-checking bench for minisys_mdu

module tb_minisys_mdu;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_mis;

    minisys_mdu_if mdif ();

    minisys_mdu #(.MULT_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .md  (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while the unit is free. Start is sampled at the
    // next rising edge (edge t); DONE is expected in cycle t+lat.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic is_div,
                          input logic [31:0] eh, input logic [31:0] el);
        logic ok;
        mdif.alu_mdE = op;
        mdif.srca    = a;
        mdif.srcb    = b;
        mdif.mdE     = 1'b1;
        @(negedge clk);
        mdif.mdE = 1'b0;
        ok = 1'b1;
        for (int c = 1; c < lat; c++) begin
            if (is_div) begin
                if (mdif.divbusyE !== 1'b1 || mdif.multbusyE !== 1'b0) ok = 1'b0;
            end else begin
                if (mdif.multbusyE !== 1'b1 || mdif.divbusyE !== 1'b0) ok = 1'b0;
            end
            if (mdif.mdcsE2D !== 1'b0 || mdif.keepmdE !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        chk({tag, ":busy"},     32'(ok), 32'd1);
        chk({tag, ":mdcs"},     32'(mdif.mdcsE2D), 32'd1);
        chk({tag, ":multover"}, 32'(mdif.multoverE), 32'(!is_div));
        chk({tag, ":divover"},  32'(mdif.divoverE), 32'(is_div));
        chk({tag, ":hi"},       mdif.mdhidataE2D, eh);
        chk({tag, ":lo"},       mdif.mdlodataE2D, el);
        @(negedge clk);
        chk({tag, ":idle"},     {30'd0, mdif.mdcsE2D, mdif.keepmdE}, 32'd0);
    endtask

    initial begin
        logic ok;
        n_vec = 0;
        n_mis = 0;
        rst          = 1'b1;
        mdif.mdE     = 1'b0;
        mdif.alu_mdE = 2'b00;
        mdif.srca    = '0;
        mdif.srcb    = '0;
        repeat (3) @(negedge clk);
        chk("rst:flags", {26'd0, mdif.keepmdE, mdif.multbusyE, mdif.multoverE,
                          mdif.divbusyE, mdif.divoverE, mdif.mdcsE2D}, 32'd0);
        chk("rst:hi", mdif.mdhidataE2D, 32'd0);
        chk("rst:lo", mdif.mdlodataE2D, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,        4,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu",     2'b01, 32'hFFFF_FFFF, 32'd2,        4,  1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("divu",      2'b11, 32'd100,       32'd7,        34, 1'b1, 32'h0000_0002, 32'h0000_000E);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        34, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF,34, 1'b1, 32'h0000_0000, 32'h8000_0000);
        run_op("div_zero",  2'b10, 32'h1234_5678, 32'd0,        34, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("divu_zero", 2'b11, 32'h8000_0001, 32'd0,        34, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF);

        // Back-to-back: MULT 3*5, DIVU 9/4 presented in the DONE cycle
        mdif.alu_mdE = 2'b00;
        mdif.srca    = 32'd3;
        mdif.srcb    = 32'd5;
        mdif.mdE     = 1'b1;
        @(negedge clk);
        mdif.mdE = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b:multover", 32'(mdif.multoverE), 32'd1);
        chk("b2b:mult_lo",  mdif.mdlodataE2D, 32'd15);
        mdif.alu_mdE = 2'b11;
        mdif.srca    = 32'd9;
        mdif.srcb    = 32'd4;
        mdif.mdE     = 1'b1;
        @(negedge clk);
        mdif.mdE = 1'b0;
        chk("b2b:nogap", {30'd0, mdif.divbusyE, mdif.keepmdE}, 32'd3);
        ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (mdif.divbusyE !== 1'b1 || mdif.mdcsE2D !== 1'b0) ok = 1'b0;
            mdif.mdE     = (c % 5 == 0);
            mdif.alu_mdE = 2'b00;
            mdif.srca    = 32'd1;
            mdif.srcb    = 32'd1;
            @(negedge clk);
        end
        mdif.mdE = 1'b0;
        chk("b2b:hold",    32'(ok), 32'd1);
        chk("b2b:divover", 32'(mdif.divoverE), 32'd1);
        chk("b2b:hi",      mdif.mdhidataE2D, 32'd1);
        chk("b2b:lo",      mdif.mdlodataE2D, 32'd2);
        @(negedge clk);
        chk("b2b:idle",    32'(mdif.keepmdE), 32'd0);

        // Reset in cycle 10 of a DIV aborts it without a strobe
        mdif.alu_mdE = 2'b10;
        mdif.srca    = 32'd100;
        mdif.srcb    = 32'd7;
        mdif.mdE     = 1'b1;
        @(negedge clk);
        mdif.mdE = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort:flags", {26'd0, mdif.keepmdE, mdif.multbusyE, mdif.multoverE,
                            mdif.divbusyE, mdif.divoverE, mdif.mdcsE2D}, 32'd0);
        chk("abort:hi", mdif.mdhidataE2D, 32'd0);
        chk("abort:lo", mdif.mdlodataE2D, 32'd0);
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (mdif.mdcsE2D !== 1'b0 || mdif.keepmdE !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("abort:quiet", 32'(ok), 32'd1);

        run_op("mult_after", 2'b00, 32'd6, 32'd7, 4, 1'b0, 32'd0, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
